// File: rtl/cic_decimator.sv
// Three-stage CIC decimator with decimation ratio R = 2^DECIM_BITS and
// differential delay 1. Integrators run at the input sample rate, gated by
// in_valid; the combs run once per R accepted samples. All internal
// arithmetic is ACC_W bits wide and wraps modulo 2^ACC_W. The integrator
// growth therefore cancels exactly in the combs. The output is the top
// OUTPUT_WIDTH bits of the last comb. With OUTPUT_WIDTH == INPUT_WIDTH this
// divides by R^3 and gives unity DC gain.
//
// Latency: the decimated sample is captured on the edge that accepts the
// R-th sample (edge T). Three comb registers and one output register follow,
// so out_valid rises on edge T+4.
module cic_decimator #(
    parameter int INPUT_WIDTH  = 12,
    parameter int OUTPUT_WIDTH = 12,
    parameter int DECIM_BITS   = 8
) (
    input  logic                           clk,
    input  logic                           arst_n,
    input  logic signed [INPUT_WIDTH-1:0]  data_in,
    input  logic                           in_valid,
    output logic signed [OUTPUT_WIDTH-1:0] data_out,
    output logic                           out_valid
);

    localparam int ACC_W = INPUT_WIDTH + 3 * DECIM_BITS;
    localparam int SHIFT = ACC_W - OUTPUT_WIDTH;
    localparam logic [DECIM_BITS-1:0] CNT_LAST = '1;

    // Widen a raw input sample to the accumulator width, preserving sign.
    function automatic logic signed [ACC_W-1:0] sign_extend(
        input logic signed [INPUT_WIDTH-1:0] v
    );
        return {{(ACC_W - INPUT_WIDTH){v[INPUT_WIDTH-1]}}, v};
    endfunction

    // Keep the top OUTPUT_WIDTH bits of a comb result. The arithmetic shift
    // drops the low bits, which rounds toward negative infinity.
    function automatic logic signed [OUTPUT_WIDTH-1:0] truncate_out(
        input logic signed [ACC_W-1:0] v
    );
        logic signed [ACC_W-1:0] shifted;
        shifted = v >>> SHIFT;
        return shifted[OUTPUT_WIDTH-1:0];
    endfunction

    logic signed [ACC_W-1:0]  x_ext;
    logic signed [ACC_W-1:0]  integ1;
    logic signed [ACC_W-1:0]  integ2;
    logic signed [ACC_W-1:0]  integ3;
    logic [DECIM_BITS-1:0]    decim_cnt;
    logic                     block_end;

    logic signed [ACC_W-1:0]  samp_p0;
    logic                     vld_p0;
    logic signed [ACC_W-1:0]  comb1_p1;
    logic signed [ACC_W-1:0]  comb1_dly;
    logic                     vld_p1;
    logic signed [ACC_W-1:0]  comb2_p2;
    logic signed [ACC_W-1:0]  comb2_dly;
    logic                     vld_p2;
    logic signed [ACC_W-1:0]  comb3_p3;
    logic signed [ACC_W-1:0]  comb3_dly;
    logic                     vld_p3;

    assign x_ext     = sign_extend(data_in);
    assign block_end = in_valid && (decim_cnt == CNT_LAST);

    // Stage p0: integrator cascade and decimation counter.
    // The pre-edge value of the last integrator is captured at block end.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            integ1    <= '0;
            integ2    <= '0;
            integ3    <= '0;
            decim_cnt <= '0;
            samp_p0   <= '0;
            vld_p0    <= 1'b0;
        end else begin
            if (in_valid) begin
                integ1    <= integ1 + x_ext;
                integ2    <= integ2 + integ1;
                integ3    <= integ3 + integ2;
                decim_cnt <= decim_cnt + 1'b1;
            end
            if (block_end) begin
                samp_p0 <= integ3;
            end
            vld_p0 <= block_end;
        end
    end

    // Stage p1: first comb section, advanced only when a new decimated sample arrives.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            comb1_p1  <= '0;
            comb1_dly <= '0;
            vld_p1    <= 1'b0;
        end else begin
            if (vld_p0) begin
                comb1_p1  <= samp_p0 - comb1_dly;
                comb1_dly <= samp_p0;
            end
            vld_p1 <= vld_p0;
        end
    end

    // Stage p2: second comb section.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            comb2_p2  <= '0;
            comb2_dly <= '0;
            vld_p2    <= 1'b0;
        end else begin
            if (vld_p1) begin
                comb2_p2  <= comb1_p1 - comb2_dly;
                comb2_dly <= comb1_p1;
            end
            vld_p2 <= vld_p1;
        end
    end

    // Stage p3: third comb section.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            comb3_p3  <= '0;
            comb3_dly <= '0;
            vld_p3    <= 1'b0;
        end else begin
            if (vld_p2) begin
                comb3_p3  <= comb2_p2 - comb3_dly;
                comb3_dly <= comb2_p2;
            end
            vld_p3 <= vld_p2;
        end
    end

    // Output register: truncated sample held between one-cycle strobes.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            data_out  <= '0;
            out_valid <= 1'b0;
        end else begin
            if (vld_p3) begin
                data_out <= truncate_out(comb3_p3);
            end
            out_valid <= vld_p3;
        end
    end

endmodule
